riscv_core_bypass_scoreboard: RTL and testbench

- Parametrised hazard-tracking and operand-forwarding unit for the RISCV pipeline; sits at the Decode stage.
- Tracks in-flight register writers in stages X..W, generates per-port bypass selects and the forwarded operand data, and raises a Decode stall when a needed value is not yet produced (load-use, iterative mul/div).
- Generalises the fixed 2-port, 3-source bypass muxing to N read ports, configurable stage depth, and variable-latency producers.

---
 rtl/riscv_core_bypass_scoreboard_if.sv | 38 +++
 rtl/riscv_core_bypass_scoreboard.sv | 142 ++++++++++++++
 tb/tb_riscv_core_bypass_scoreboard.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_bypass_scoreboard_if.sv
// Decode-side bus of the bypass scoreboard: Decode fields, operand sources, back-end
// status and the resulting bypass selects, forwarded data and stall.
interface riscv_core_bypass_scoreboard_if #(
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_STAGES   = 3,
  parameter int SELW         = 2
);
  logic                         dec_val;
  logic                         dec_squash;
  logic                         dec_wen;
  logic [4:0]                   dec_rd;
  logic                         dec_ld;
  logic                         dec_var;
  logic [5*NUM_RD_PORTS-1:0]    dec_rs;
  logic [NUM_RD_PORTS-1:0]      dec_ren;
  logic [XLEN*NUM_RD_PORTS-1:0] rf_rdata;
  logic [XLEN*NUM_STAGES-1:0]   stage_data;
  logic                         hold;
  logic                         x_done;
  logic [SELW*NUM_RD_PORTS-1:0] byp_sel;
  logic [XLEN*NUM_RD_PORTS-1:0] byp_data;
  logic                         stall_D;
  logic [31:0]                  perf_stall_cnt;
  logic [31:0]                  perf_byp_cnt;

  modport master (
    output dec_val, dec_squash, dec_wen, dec_rd, dec_ld, dec_var, dec_rs, dec_ren,
           rf_rdata, stage_data, hold, x_done,
    input  byp_sel, byp_data, stall_D, perf_stall_cnt, perf_byp_cnt
  );

  modport slave (
    input  dec_val, dec_squash, dec_wen, dec_rd, dec_ld, dec_var, dec_rs, dec_ren,
           rf_rdata, stage_data, hold, x_done,
    output byp_sel, byp_data, stall_D, perf_stall_cnt, perf_byp_cnt
  );
endinterface

// File: rtl/riscv_core_bypass_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers in X..W, forwards operands and
// raises stall_D. Optional performance counters are enabled with RISCV_BYP_PERF_EN.
module riscv_core_bypass_scoreboard #(
  parameter int XLEN         = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_STAGES   = 3,
  parameter int SELW         = 2
) (
  input logic                           clk,
  input logic                           reset,
  riscv_core_bypass_scoreboard_if.slave bus
);

  logic [NUM_STAGES-1:0]        val_r;
  logic [NUM_STAGES-1:0]        wen_r;
  logic [NUM_STAGES-1:0]        ld_r;
  logic [NUM_STAGES-1:0]        vlat_r;
  logic [4:0]                   rd_r [NUM_STAGES];
  logic [NUM_RD_PORTS-1:0]      stall_req_s;
  logic [SELW*NUM_RD_PORTS-1:0] sel_s;
  logic [XLEN*NUM_RD_PORTS-1:0] data_s;
  logic                         stall_s;
  logic                         issue_s;

  // Only the X slot can hold a result that is not yet produced (load, or mul/div not done).
  function automatic logic slot_avail(input int s, input logic ld, input logic vlat,
                                      input logic done);
    if (s == 0) begin
      return (~ld & ~vlat) | (vlat & done);
    end else begin
      return 1'b1;
    end
  endfunction

  // Per-port youngest-match search, availability check and operand mux
  always_comb begin
    logic found;
    sel_s       = '0;
    data_s      = bus.rf_rdata;
    stall_req_s = '0;
    found       = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      found = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!found && bus.dec_ren[p] && val_r[s] && wen_r[s] &&
            (rd_r[s] == bus.dec_rs[5*p +: 5]) && (rd_r[s] != 5'd0)) begin
          found = 1'b1;
          if (slot_avail(s, ld_r[s], vlat_r[s], bus.x_done)) begin
            sel_s[SELW*p +: SELW]  = SELW'(s + 1);
            data_s[XLEN*p +: XLEN] = bus.stage_data[XLEN*s +: XLEN];
          end else begin
            stall_req_s[p] = 1'b1;
          end
        end else begin
          found = found;
        end
      end
    end
  end

  // A squashed instruction never stalls; hold freezes Decode regardless
  always_comb begin
    stall_s = bus.hold | (bus.dec_val & ~bus.dec_squash & (|stall_req_s));
    issue_s = bus.dec_val & ~bus.dec_squash & ~stall_s & ~bus.hold;
  end

  assign bus.byp_sel  = sel_s;
  assign bus.byp_data = data_s;
  assign bus.stall_D  = stall_s;

  // Slot shift register: Decode enters slot 0, the last slot retires on advance
  always_ff @(posedge clk) begin
    if (reset) begin
      val_r  <= '0;
      wen_r  <= '0;
      ld_r   <= '0;
      vlat_r <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        rd_r[s] <= 5'd0;
      end
    end else if (!bus.hold) begin
      for (int s = NUM_STAGES - 1; s > 0; s--) begin
        val_r[s]  <= val_r[s-1];
        wen_r[s]  <= wen_r[s-1];
        ld_r[s]   <= ld_r[s-1];
        vlat_r[s] <= vlat_r[s-1];
        rd_r[s]   <= rd_r[s-1];
      end
      val_r[0]  <= issue_s;
      wen_r[0]  <= bus.dec_wen;
      ld_r[0]   <= bus.dec_ld;
      vlat_r[0] <= bus.dec_var;
      rd_r[0]   <= bus.dec_rd;
    end else begin
      val_r <= val_r;
    end
  end

`ifdef RISCV_BYP_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_byp_r;
  logic [31:0] byp_ports_s;

  // Number of ports forwarding this cycle
  always_comb begin
    byp_ports_s = 32'd0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (sel_s[SELW*p +: SELW] != '0) begin
        byp_ports_s = byp_ports_s + 32'd1;
      end else begin
        byp_ports_s = byp_ports_s;
      end
    end
  end

  // Free-running wrap-around event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_r <= 32'd0;
      perf_byp_r   <= 32'd0;
    end else begin
      if (bus.dec_val && !bus.dec_squash && stall_s && !bus.hold) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (issue_s) begin
        perf_byp_r <= perf_byp_r + byp_ports_s;
      end else begin
        perf_byp_r <= perf_byp_r;
      end
    end
  end

  assign bus.perf_stall_cnt = perf_stall_r;
  assign bus.perf_byp_cnt   = perf_byp_r;
`else
  assign bus.perf_stall_cnt = 32'd0;
  assign bus.perf_byp_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_core_bypass_scoreboard.sv
// Directed bench for riscv_core_bypass_scoreboard with the default 2-port, 3-slot setup.
module tb_riscv_core_bypass_scoreboard;
  localparam int XLEN = 32;
  localparam int NP   = 2;
  localparam int NS   = 3;
  localparam int SELW = 2;
  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  riscv_core_bypass_scoreboard_if #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .NUM_STAGES(NS), .SELW(SELW)) bus();

  riscv_core_bypass_scoreboard #(.XLEN(XLEN), .NUM_RD_PORTS(NP), .NUM_STAGES(NS), .SELW(SELW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_val    = 1'b0;
    bus.dec_squash = 1'b0;
    bus.dec_wen    = 1'b0;
    bus.dec_rd     = 5'd0;
    bus.dec_ld     = 1'b0;
    bus.dec_var    = 1'b0;
    bus.dec_rs     = 10'd0;
    bus.dec_ren    = 2'b00;
    bus.hold       = 1'b0;
    bus.x_done     = 1'b0;
  endtask

  task automatic flush();
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld, input logic vl);
    idle();
    bus.dec_val = 1'b1;
    bus.dec_wen = wen;
    bus.dec_rd  = rd;
    bus.dec_ld  = ld;
    bus.dec_var = vl;
    #1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    bus.dec_val = 1'b1;
    bus.dec_rs  = {5'd6, 5'd5};
    bus.dec_ren = 2'b11;
    tick();
    tick();
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b want=0", bus.stall_D); end
    total++; if (bus.byp_sel !== 4'd0) begin bad++; $display("FAIL rst_sel got=%h want=0", bus.byp_sel); end
    total++; if (bus.byp_data !== {RF1, RF0}) begin bad++; $display("FAIL rst_data got=%h want=%h", bus.byp_data, {RF1, RF0}); end
    reset = 1'b0;
    tick();
    total++; if (bus.byp_sel !== 4'd0 || bus.stall_D !== 1'b0) begin bad++; $display("FAIL post_rst got sel=%h stall=%0b want 0/0", bus.byp_sel, bus.stall_D); end
  endtask

  task automatic test_alu_b2b();
    flush();
    bus.stage_data = {32'h0, 32'h0, 32'h11};
    idle();
    bus.dec_val = 1'b1; bus.dec_wen = 1'b1; bus.dec_rd = 5'd5;
    #1;
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL alu_issue_stall got=%0b want=0", bus.stall_D); end
    tick();
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd9, 5'd5}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.byp_sel !== 4'b0001) begin bad++; $display("FAIL alu_sel got=%h want=1", bus.byp_sel); end
    total++; if (bus.byp_data !== {RF1, 32'h11}) begin bad++; $display("FAIL alu_data got=%h want=%h", bus.byp_data, {RF1, 32'h11}); end
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b want=0", bus.stall_D); end
  endtask

  task automatic test_load_use();
    flush();
    bus.stage_data = {32'h0, 32'hDEADBEEF, 32'h55};
    issue(5'd6, 1'b1, 1'b1, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd6, 5'd0}; bus.dec_ren = 2'b10;
    #1;
    total++; if (bus.stall_D !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%0b want=1", bus.stall_D); end
    tick();
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%0b want=0", bus.stall_D); end
    total++; if (bus.byp_sel !== 4'b1000) begin bad++; $display("FAIL lu_sel got=%h want=8", bus.byp_sel); end
    total++; if (bus.byp_data !== {32'hDEADBEEF, RF0}) begin bad++; $display("FAIL lu_data got=%h want=%h", bus.byp_data, {32'hDEADBEEF, RF0}); end
  endtask

  task automatic test_priority();
    flush();
    bus.stage_data = {32'h3, 32'h5, 32'h9};
    issue(5'd7, 1'b1, 1'b0, 1'b0);
    issue(5'd7, 1'b0, 1'b0, 1'b0);
    issue(5'd7, 1'b1, 1'b0, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd7, 5'd7}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.byp_sel !== 4'b0101) begin bad++; $display("FAIL prio_sel got=%h want=5", bus.byp_sel); end
    total++; if (bus.byp_data !== {32'h9, 32'h9}) begin bad++; $display("FAIL prio_data got=%h want=%h", bus.byp_data, {32'h9, 32'h9}); end
    bus.dec_val = 1'b0;
    tick();
    total++; if (bus.byp_sel !== 4'b1010 || bus.byp_data !== {32'h5, 32'h5}) begin bad++; $display("FAIL prio_m got sel=%h data=%h want sel=a data=5/5", bus.byp_sel, bus.byp_data); end
    tick();
    total++; if (bus.byp_sel !== 4'b1111 || bus.byp_data !== {32'h3, 32'h3}) begin bad++; $display("FAIL prio_w got sel=%h data=%h want sel=f data=3/3", bus.byp_sel, bus.byp_data); end
    tick();
    total++; if (bus.byp_sel !== 4'b0000 || bus.byp_data !== {RF1, RF0}) begin bad++; $display("FAIL prio_retire got sel=%h data=%h want sel=0 rf", bus.byp_sel, bus.byp_data); end
  endtask

  task automatic test_x0_ren();
    flush();
    bus.stage_data = {32'h0, 32'h0, 32'h77};
    issue(5'd0, 1'b1, 1'b0, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd0, 5'd0}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.byp_sel !== 4'd0 || bus.byp_data !== {RF1, RF0}) begin bad++; $display("FAIL x0 got sel=%h data=%h want sel=0 rf", bus.byp_sel, bus.byp_data); end
    flush();
    issue(5'd6, 1'b1, 1'b1, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd6, 5'd6}; bus.dec_ren = 2'b00;
    #1;
    total++; if (bus.stall_D !== 1'b0 || bus.byp_sel !== 4'd0) begin bad++; $display("FAIL ren_off got stall=%0b sel=%h want 0/0", bus.stall_D, bus.byp_sel); end
    bus.dec_ren = 2'b01;
    #1;
    total++; if (bus.stall_D !== 1'b1) begin bad++; $display("FAIL ren_on got=%0b want=1", bus.stall_D); end
  endtask

  task automatic test_muldiv();
    flush();
    bus.stage_data = {32'h0, 32'h0, 32'h2A};
    issue(5'd8, 1'b1, 1'b0, 1'b1);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd0, 5'd8}; bus.dec_ren = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.hold = 1'b0; bus.x_done = 1'b0;
      #1;
      total++; if (bus.stall_D !== 1'b1) begin bad++; $display("FAIL md_wait%0d got=%0b want=1", i, bus.stall_D); end
      bus.hold = 1'b1;
      #1;
      total++; if (bus.stall_D !== 1'b1) begin bad++; $display("FAIL md_hold%0d got=%0b want=1", i, bus.stall_D); end
      tick();
    end
    bus.hold = 1'b0; bus.x_done = 1'b1;
    #1;
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL md_done_stall got=%0b want=0", bus.stall_D); end
    total++; if (bus.byp_sel !== 4'b0001 || bus.byp_data[31:0] !== 32'h2A) begin bad++; $display("FAIL md_done got sel=%h data=%h want sel=1 data=2a", bus.byp_sel, bus.byp_data[31:0]); end
  endtask

  task automatic test_squash();
    flush();
    bus.stage_data = {32'h0, 32'hDEADBEEF, 32'h0};
    issue(5'd6, 1'b1, 1'b1, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_squash = 1'b1; bus.dec_wen = 1'b1; bus.dec_rd = 5'd9;
    bus.dec_rs = {5'd6, 5'd6}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.stall_D !== 1'b0) begin bad++; $display("FAIL sq_stall got=%0b want=0", bus.stall_D); end
    tick();
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd9, 5'd6}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.byp_sel !== 4'b0010 || bus.stall_D !== 1'b0) begin bad++; $display("FAIL sq_bubble got sel=%h stall=%0b want sel=2 stall=0", bus.byp_sel, bus.stall_D); end
    total++; if (bus.byp_data !== {RF1, 32'hDEADBEEF}) begin bad++; $display("FAIL sq_data got=%h want=%h", bus.byp_data, {RF1, 32'hDEADBEEF}); end
  endtask

  task automatic test_perf();
`ifdef RISCV_BYP_PERF_EN
    total++; if (bus.perf_stall_cnt == 32'd0 || bus.perf_byp_cnt == 32'd0) begin bad++; $display("FAIL perf_cnt got stall=%0d byp=%0d want nonzero", bus.perf_stall_cnt, bus.perf_byp_cnt); end
`else
    total++; if (bus.perf_stall_cnt !== 32'd0 || bus.perf_byp_cnt !== 32'd0) begin bad++; $display("FAIL perf_tie got stall=%0d byp=%0d want 0/0", bus.perf_stall_cnt, bus.perf_byp_cnt); end
`endif
  endtask

  task automatic test_reset_inflight();
    flush();
    bus.stage_data = {32'h3C, 32'h2B, 32'h1A};
    issue(5'd10, 1'b1, 1'b0, 1'b0);
    issue(5'd11, 1'b1, 1'b0, 1'b0);
    issue(5'd12, 1'b1, 1'b0, 1'b0);
    idle();
    bus.dec_val = 1'b1; bus.dec_rs = {5'd11, 5'd10}; bus.dec_ren = 2'b11;
    #1;
    total++; if (bus.byp_sel !== 4'b1011) begin bad++; $display("FAIL rst_pre got=%h want=b", bus.byp_sel); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    total++; if (bus.byp_sel !== 4'd0 || bus.stall_D !== 1'b0 || bus.byp_data !== {RF1, RF0}) begin bad++; $display("FAIL rst_flush got sel=%h stall=%0b data=%h want 0/0/rf", bus.byp_sel, bus.stall_D, bus.byp_data); end
  endtask

  initial begin
    bus.rf_rdata   = {RF1, RF0};
    bus.stage_data = '0;
    test_reset();
    test_alu_b2b();
    test_load_use();
    test_priority();
    test_x0_ren();
    test_muldiv();
    test_squash();
    test_perf();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
